// File: rtl/ser_ctrl_pkg.sv
// Shared types and helpers for the serializer TX scheduler.
package ser_ctrl_pkg;

  localparam int unsigned SER_DATA_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    DONE
  } ser_state_e;

  // Width of a requester index; at least one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr+1, wrapping.
module ser_rr_picker
  import ser_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [grant_w(NUM_REQ)-1:0] ptr,
  output logic                        found,
  output logic [grant_w(NUM_REQ)-1:0] idx
);

  localparam int unsigned GW = grant_w(NUM_REQ);

  // Distance of channel k from the highest-priority slot ptr+1.
  function automatic int unsigned rr_dist(input int unsigned k, input logic [GW-1:0] p);
    return (k + NUM_REQ - int'(p) - 1) % NUM_REQ;
  endfunction

  always_comb begin
    int unsigned best;
    best  = NUM_REQ;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req[k] && (rr_dist(k, ptr) < best)) begin
        best  = rr_dist(k, ptr);
        found = 1'b1;
        idx   = GW'(k);
      end
    end
  end

endmodule

// File: rtl/serializer_tx_scheduler.sv
// Shares one serializer among NUM_REQ requesters with round-robin arbitration.
// Optional BUSY watchdog enabled by defining SER_TX_TIMEOUT_EN.
module serializer_tx_scheduler
  import ser_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = SER_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        ser_start,
  output logic [DATA_W-1:0]           ser_data,
  input  logic                        ser_data_sent,
  output logic                        busy,
  output logic [grant_w(NUM_REQ)-1:0] grant_id,
  output logic                        tx_err
);

  localparam int unsigned GW = grant_w(NUM_REQ);

  ser_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [DATA_W-1:0] pick_data;

  ser_rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == GW'(k)) pick_data = req_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef SER_TX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
`ifdef SER_TX_TIMEOUT_EN
    cnt_d = cnt_q;
    to_d  = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOAD;
          grant_d = pick_idx;
          data_d  = pick_data;
        end
      end
      LOAD: begin
        state_d = BUSY;
`ifdef SER_TX_TIMEOUT_EN
        cnt_d = '0;
        to_d  = 1'b0;
`endif
      end
      BUSY: begin
        if (ser_data_sent) begin
          state_d = DONE;
`ifdef SER_TX_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

`ifdef SER_TX_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign tx_err = (state_q == DONE) && to_q;
`else
  assign tx_err = 1'b0;
`endif

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      ack[k] = (state_q == DONE) && (grant_q == GW'(k));
    end
  end

  assign busy      = (state_q != IDLE);
  assign ser_start = (state_q == LOAD);
  assign ser_data  = data_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_serializer_tx_scheduler.sv
// Randomized self-checking bench for serializer_tx_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_serializer_tx_scheduler;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           ser_data_sent = 1'b0;
  logic [N-1:0]   ack;
  logic           ser_start;
  logic [W-1:0]   ser_data;
  logic           busy;
  logic [1:0]     grant_id;
  logic           tx_err;

  serializer_tx_scheduler #(
    .NUM_REQ       (N),
    .DATA_W        (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .ser_start    (ser_start),
    .ser_data     (ser_data),
    .ser_data_sent(ser_data_sent),
    .busy         (busy),
    .grant_id     (grant_id),
    .tx_err       (tx_err)
  );

  always #5 clock = ~clock;

  int           vecs = 0;
  int           errs = 0;
  logic [N-1:0] req_v = '0;
  logic [W-1:0] data_v [N];
  int           ptr = N - 1;

  // Reference arbitration: scan channels starting just after the last served one.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    req = req_v;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = data_v[k];
  endtask

  task automatic raise(input int k, input logic [W-1:0] d);
    if (!req_v[k]) begin
      req_v[k]  = 1'b1;
      data_v[k] = d;
    end
  endtask

  // Entry: just after a rising edge, DUT idle, req_v already driven.
  task automatic do_xfer(input int delay, input bit stale, output int g);
    logic [N-1:0] exp_ack;
    g = model_pick(req_v, ptr);
    exp_ack = N'(1) << g;
    @(negedge clock);
    vecs++;
    if (busy !== 1'b0 || ack !== '0) begin
      errs++;
      $display("FAIL idle_state busy=%b ack=%b required busy=0 ack=0", busy, ack);
    end
    @(posedge clock); #1;
    if (stale) ser_data_sent = 1'b1;
    @(negedge clock);
    vecs++;
    if (ser_start !== 1'b1 || busy !== 1'b1 || grant_id !== 2'(g) || ser_data !== data_v[g]) begin
      errs++;
      $display("FAIL load start=%b busy=%b grant=%0d data=%h required start=1 busy=1 grant=%0d data=%h",
               ser_start, busy, grant_id, ser_data, g, data_v[g]);
    end
    @(posedge clock); #1;
    ser_data_sent = 1'b0;
    repeat (delay) begin
      @(negedge clock);
      vecs++;
      if (busy !== 1'b1 || ser_start !== 1'b0 || ack !== '0 || ser_data !== data_v[g]) begin
        errs++;
        $display("FAIL busy_wait busy=%b start=%b ack=%b data=%h required busy=1 start=0 ack=0 data=%h",
                 busy, ser_start, ack, ser_data, data_v[g]);
      end
      @(posedge clock); #1;
    end
    ser_data_sent = 1'b1;
    @(posedge clock); #1;
    ser_data_sent = 1'b0;
    @(negedge clock);
    vecs++;
    if (ack !== exp_ack || tx_err !== 1'b0 || busy !== 1'b1 || ser_start !== 1'b0) begin
      errs++;
      $display("FAIL done_ack ack=%b tx_err=%b busy=%b required ack=%b tx_err=0 busy=1",
               ack, tx_err, busy, exp_ack);
    end
    @(posedge clock); #1;
    req_v[g] = 1'b0;
    ptr      = g;
    drive();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive();
    repeat (2) @(negedge clock);
    vecs++;
    if (ack !== '0 || ser_start !== 1'b0 || busy !== 1'b0 || tx_err !== 1'b0 ||
        ser_data !== '0 || grant_id !== '0) begin
      errs++;
      $display("FAIL reset ack=%b start=%b busy=%b tx_err=%b data=%h grant=%0d required all zero",
               ack, ser_start, busy, tx_err, ser_data, grant_id);
    end
    resetn = 1'b1;
    ptr    = N - 1;
    @(posedge clock); #1;
  endtask

  task automatic test_round_robin();
    int g;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) raise(k, W'($urandom));
    drive();
    for (int t = 0; t < 5; t++) begin
      do_xfer($urandom_range(0, 3), 1'b0, g);
      vecs++;
      if (g !== order[t]) begin
        errs++;
        $display("FAIL rr_order step=%0d model=%0d required %0d", t, g, order[t]);
      end
      if (t < 4) begin
        raise(g, W'($urandom));
        drive();
      end
    end
    while (req_v != '0) do_xfer(1, 1'b0, g);
  endtask

  task automatic test_single();
    int g;
    raise(2, 14'h2A5C);
    drive();
    do_xfer(3, 1'b0, g);
  endtask

  task automatic test_stale_sent();
    int g;
    raise(1, W'($urandom));
    drive();
    do_xfer(3, 1'b1, g);
  endtask

  task automatic test_reset_mid();
    int g;
    raise(1, W'($urandom));
    drive();
    do_xfer(0, 1'b0, g);
    raise(2, W'($urandom));
    drive();
    repeat (3) begin
      @(posedge clock); #1;
    end
    resetn = 1'b0;
    req_v  = '0;
    drive();
    #2;
    vecs++;
    if (ack !== '0 || ser_start !== 1'b0 || busy !== 1'b0 || tx_err !== 1'b0 ||
        ser_data !== '0 || grant_id !== '0) begin
      errs++;
      $display("FAIL reset_mid ack=%b start=%b busy=%b tx_err=%b data=%h grant=%0d required all zero",
               ack, ser_start, busy, tx_err, ser_data, grant_id);
    end
    @(negedge clock);
    resetn = 1'b1;
    ptr    = N - 1;
    @(posedge clock); #1;
    raise(1, W'($urandom));
    raise(3, W'($urandom));
    drive();
    do_xfer(2, 1'b0, g);
    do_xfer(1, 1'b0, g);
  endtask

  task automatic test_timeout();
    raise(0, W'($urandom));
    drive();
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    vecs++;
    if (ser_start !== 1'b1 || grant_id !== 2'(model_pick(req_v, ptr))) begin
      errs++;
      $display("FAIL to_load start=%b grant=%0d required start=1 grant=%0d",
               ser_start, grant_id, model_pick(req_v, ptr));
    end
`ifdef SER_TX_TIMEOUT_EN
    repeat (TO) begin
      @(negedge clock);
      vecs++;
      if (busy !== 1'b1 || ack !== '0 || tx_err !== 1'b0) begin
        errs++;
        $display("FAIL to_wait busy=%b ack=%b tx_err=%b required busy=1 ack=0 tx_err=0",
                 busy, ack, tx_err);
      end
    end
    @(negedge clock);
    vecs++;
    if (ack !== 4'b0001 || tx_err !== 1'b1) begin
      errs++;
      $display("FAIL to_expire ack=%b tx_err=%b required ack=0001 tx_err=1", ack, tx_err);
    end
`else
    repeat (3 * TO) begin
      @(negedge clock);
      vecs++;
      if (busy !== 1'b1 || ack !== '0 || tx_err !== 1'b0) begin
        errs++;
        $display("FAIL no_to_wait busy=%b ack=%b tx_err=%b required busy=1 ack=0 tx_err=0",
                 busy, ack, tx_err);
      end
    end
    @(posedge clock); #1;
    ser_data_sent = 1'b1;
    @(posedge clock); #1;
    ser_data_sent = 1'b0;
    @(negedge clock);
    vecs++;
    if (ack !== 4'b0001 || tx_err !== 1'b0) begin
      errs++;
      $display("FAIL no_to_done ack=%b tx_err=%b required ack=0001 tx_err=0", ack, tx_err);
    end
`endif
    @(posedge clock); #1;
    req_v[0] = 1'b0;
    ptr      = 0;
    drive();
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 40; t++) begin
      if (req_v == '0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clock);
          vecs++;
          if (busy !== 1'b0 || ack !== '0) begin
            errs++;
            $display("FAIL rand_gap busy=%b ack=%b required busy=0 ack=0", busy, ack);
          end
          @(posedge clock); #1;
        end
      end
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) raise(k, W'($urandom));
      end
      if (req_v == '0) raise($urandom_range(0, N - 1), W'($urandom));
      drive();
      do_xfer($urandom_range(0, 6), ($urandom_range(0, 3) == 0), g);
    end
    while (req_v != '0) do_xfer(1, 1'b0, g);
  endtask

  initial begin
    for (int k = 0; k < N; k++) data_v[k] = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_stale_sent();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
